multi_pattern_detector: RTL

//  Parametrised serial pattern detector: NUM_PAT independently programmed, bit-maskable
//  PAT_W-bit patterns compared against a sliding window of the serial input stream.

---
 rtl/multi_pattern_detector.sv | 125 ++++++++++++
 1 files changed

// File: rtl/multi_pattern_detector.sv
// Serial pattern detector: NUM_PAT bit-maskable PAT_W-bit patterns compared against a
// sliding window of the input stream, with per-channel serial programming and arming.
module multi_pattern_detector #(
  parameter int PAT_W   = 1024,
  parameter int NUM_PAT = 4,
  parameter int CNT_W   = 16,
  localparam int SEL_W  = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               sig,
  input  logic               sig_valid,
  input  logic               prgm_en,
  input  logic [SEL_W-1:0]   prgm_sel,
  input  logic               prgm_bit,
  input  logic               prgm_mask,
  output logic               match,
  output logic [NUM_PAT-1:0] match_vec,
  output logic [SEL_W-1:0]   match_id,
  output logic [CNT_W-1:0]   match_count,
  output logic [NUM_PAT-1:0] armed
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FULL    = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FULL_M1 = FILL_W'(PAT_W - 1);

  logic [PAT_W-1:0]   win_q, win_d, nwin;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [PAT_W-1:0]   pat_q [NUM_PAT];
  logic [PAT_W-1:0]   pat_d [NUM_PAT];
  logic [PAT_W-1:0]   msk_q [NUM_PAT];
  logic [PAT_W-1:0]   msk_d [NUM_PAT];
  logic [FILL_W-1:0]  ld_cnt_q [NUM_PAT];
  logic [FILL_W-1:0]  ld_cnt_d [NUM_PAT];
  logic [FILL_W-1:0]  ld_next;
  logic [NUM_PAT-1:0] armed_q, armed_d;
  logic [NUM_PAT-1:0] hit;
  logic               filled_next;
  logic               match_q, match_d;
  logic [NUM_PAT-1:0] match_vec_q;
  logic [SEL_W-1:0]   match_id_q, match_id_d;
  logic [CNT_W-1:0]   match_count_q, match_count_d;

  always_comb begin
    win_d         = win_q;
    fill_d        = fill_q;
    pat_d         = pat_q;
    msk_d         = msk_q;
    ld_cnt_d      = ld_cnt_q;
    armed_d       = armed_q;
    hit           = '0;
    ld_next       = '0;
    match_id_d    = '0;
    match_count_d = match_count_q;

    nwin = sig_valid ? {win_q[PAT_W-2:0], sig} : win_q;
    // hit already requires sig_valid, so one short of full is enough here
    filled_next = (fill_q >= FULL_M1);

    if (sig_valid) begin
      win_d = nwin;
      if (fill_q != FULL) fill_d = fill_q + 1'b1;
    end

    for (int k = 0; k < NUM_PAT; k++) begin
      hit[k] = sig_valid & armed_q[k] & filled_next &
               ~|((nwin ^ pat_q[k]) & msk_q[k]);

      if (prgm_en && (int'(prgm_sel) == k)) begin
        pat_d[k] = {pat_q[k][PAT_W-2:0], prgm_bit};
        msk_d[k] = {msk_q[k][PAT_W-2:0], prgm_mask};
        if (armed_q[k]) begin
          armed_d[k]  = 1'b0;
          ld_cnt_d[k] = FILL_W'(1);
        end else begin
          ld_next     = ld_cnt_q[k] + 1'b1;
          ld_cnt_d[k] = ld_next;
          if (ld_next == FULL) armed_d[k] = 1'b1;
        end
      end
    end

    // scan downward so the lowest set index is the one left standing
    for (int k = NUM_PAT - 1; k >= 0; k--) begin
      if (hit[k]) match_id_d = SEL_W'(k);
    end

    match_d = |hit;
    if (match_d && (match_count_q != '1)) match_count_d = match_count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      win_q         <= '0;
      fill_q        <= '0;
      pat_q         <= '{default: '0};
      msk_q         <= '{default: '0};
      ld_cnt_q      <= '{default: '0};
      armed_q       <= '0;
      match_q       <= 1'b0;
      match_vec_q   <= '0;
      match_id_q    <= '0;
      match_count_q <= '0;
    end else begin
      win_q         <= win_d;
      fill_q        <= fill_d;
      pat_q         <= pat_d;
      msk_q         <= msk_d;
      ld_cnt_q      <= ld_cnt_d;
      armed_q       <= armed_d;
      match_q       <= match_d;
      match_vec_q   <= hit;
      match_id_q    <= match_id_d;
      match_count_q <= match_count_d;
    end
  end

  assign match       = match_q;
  assign match_vec   = match_vec_q;
  assign match_id    = match_id_q;
  assign match_count = match_count_q;
  assign armed       = armed_q;

endmodule
